// File: rtl/riscv_regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_regfile_sb_pkg: shared widths and legal-value constants for the regfile.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package riscv_regfile_sb_pkg;

  localparam int XLEN_DEFAULT = `XLEN;
  localparam int REG_AW       = 5;
  localparam int REG_SLOTS    = 1 << REG_AW;
  localparam int NREG_RV32E   = 16;
  localparam int NREG_RV32I   = 32;
  localparam int CNT_W        = 6;

  // A write or set target: non-zero and inside the architectural register count.
  function automatic logic addr_legal(input logic [REG_AW-1:0] addr, input int nreg);
    return (addr != '0) && (int'(addr) < nreg);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// riscv_regfile_scoreboard: per-register busy bits with set-over-clear priority
// and a registered popcount.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_regfile_scoreboard
  import riscv_regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_RV32I
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [REG_AW-1:0]     set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_AW-1:0]     clr_addr_i,
  output logic [REG_SLOTS-1:0]  busy_o,
  output logic [CNT_W-1:0]      cnt_o
);

  logic [REG_SLOTS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Bit 0 and bits at or above NREG are never produced, so they stay zero.
  always_comb begin
    busy_d = '0;
    cnt_d  = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_d[r] = (set_i && (set_addr_i == REG_AW'(r))) ||
                  (busy_q[r] && !(clr_i && (clr_addr_i == REG_AW'(r))));
    end
    for (int r = 0; r < REG_SLOTS; r++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/riscv_regfile_sb.sv
// ---------------------------------------------------------------------------
// riscv_regfile_sb: RV32I/E register file, N read ports, two write ports, busy
// scoreboard. Define RISCV_REGFILE_BYPASS_EN for same-cycle write bypass. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile_sb
  import riscv_regfile_sb_pkg::*;
#(
  parameter int XLEN = `XLEN,
  parameter int NREG = NREG_RV32I,
  parameter int NRD  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [NRD*REG_AW-1:0]   i_regfile_rs_addr,
  output logic [NRD*XLEN-1:0]     o_regfile_rs_data,
  output logic [NRD-1:0]          o_regfile_rs_busy,
  input  logic                    i_regfile_rd0_wen,
  input  logic [REG_AW-1:0]       i_regfile_rd0_addr,
  input  logic [XLEN-1:0]         i_regfile_rd0_data,
  input  logic                    i_regfile_rd1_wen,
  input  logic [REG_AW-1:0]       i_regfile_rd1_addr,
  input  logic [XLEN-1:0]         i_regfile_rd1_data,
  input  logic                    i_regfile_sb_set,
  input  logic [REG_AW-1:0]       i_regfile_sb_addr,
  output logic [CNT_W-1:0]        o_regfile_sb_cnt
);

  logic [XLEN-1:0]      regs_q [REG_SLOTS];
  logic [REG_SLOTS-1:0] busy;
  logic                 w0_ok, w1_ok;

  assign w0_ok = i_regfile_rd0_wen && addr_legal(i_regfile_rd0_addr, NREG);
  assign w1_ok = i_regfile_rd1_wen && addr_legal(i_regfile_rd1_addr, NREG);

  // Port 0 is assigned last so it wins a same-address collision.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < REG_SLOTS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (w1_ok) regs_q[i_regfile_rd1_addr] <= i_regfile_rd1_data;
      if (w0_ok) regs_q[i_regfile_rd0_addr] <= i_regfile_rd0_data;
    end
  end

  riscv_regfile_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk_i      (i_clk),
    .rst_ni     (i_rstn),
    .set_i      (i_regfile_sb_set),
    .set_addr_i (i_regfile_sb_addr),
    .clr_i      (i_regfile_rd1_wen),
    .clr_addr_i (i_regfile_rd1_addr),
    .busy_o     (busy),
    .cnt_o      (o_regfile_sb_cnt)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [REG_AW-1:0] addr;
    logic              in_range;
    logic [XLEN-1:0]   stored;
    logic [XLEN-1:0]   rdata;
    logic              rbusy;

    assign addr     = i_regfile_rs_addr[k*REG_AW +: REG_AW];
    assign in_range = int'(addr) < NREG;
    assign stored   = in_range ? regs_q[addr] : '0;

`ifdef RISCV_REGFILE_BYPASS_EN
    // w*_ok already excludes x0 and out-of-range targets.
    always_comb begin
      rdata = stored;
      rbusy = busy[addr];
      if (w0_ok && (i_regfile_rd0_addr == addr)) begin
        rdata = i_regfile_rd0_data;
      end else if (w1_ok && (i_regfile_rd1_addr == addr)) begin
        rdata = i_regfile_rd1_data;
      end
      if (w1_ok && (i_regfile_rd1_addr == addr) &&
          !(i_regfile_sb_set && (i_regfile_sb_addr == addr))) begin
        rbusy = 1'b0;
      end
    end
`else
    assign rdata = stored;
    assign rbusy = busy[addr];
`endif

    assign o_regfile_rs_data[k*XLEN +: XLEN] = rdata;
    assign o_regfile_rs_busy[k]              = rbusy;
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_riscv_regfile_sb: scoreboard bench driving an RV32I and an RV32E instance
// with shared stimulus against an array-based reference model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_riscv_regfile_sb;

  localparam int NRD = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NRD-1:0][4:0] ra;
  logic        w0, w1, sset;
  logic [4:0]  a0, a1, sa;
  logic [31:0] d0, d1;

  logic [NRD*32-1:0] rd_i, rd_e;
  logic [NRD-1:0]    bz_i, bz_e;
  logic [5:0]        cnt_i, cnt_e;

  riscv_regfile_sb #(.XLEN(32), .NREG(32), .NRD(NRD)) dut_i (
    .i_clk(clk), .i_rstn(rstn), .i_regfile_rs_addr(ra),
    .o_regfile_rs_data(rd_i), .o_regfile_rs_busy(bz_i),
    .i_regfile_rd0_wen(w0), .i_regfile_rd0_addr(a0), .i_regfile_rd0_data(d0),
    .i_regfile_rd1_wen(w1), .i_regfile_rd1_addr(a1), .i_regfile_rd1_data(d1),
    .i_regfile_sb_set(sset), .i_regfile_sb_addr(sa), .o_regfile_sb_cnt(cnt_i));

  riscv_regfile_sb #(.XLEN(32), .NREG(16), .NRD(NRD)) dut_e (
    .i_clk(clk), .i_rstn(rstn), .i_regfile_rs_addr(ra),
    .o_regfile_rs_data(rd_e), .o_regfile_rs_busy(bz_e),
    .i_regfile_rd0_wen(w0), .i_regfile_rd0_addr(a0), .i_regfile_rd0_data(d0),
    .i_regfile_rd1_wen(w1), .i_regfile_rd1_addr(a1), .i_regfile_rd1_data(d1),
    .i_regfile_sb_set(sset), .i_regfile_sb_addr(sa), .o_regfile_sb_cnt(cnt_e));

  // Reference model: architectural contents and busy set per instance.
  logic [31:0] m  [2][32];
  bit          mb [2][32];
  int          nreg [2] = '{32, 16};

  typedef struct packed {
    logic [1:0][NRD-1:0][31:0] data;
    logic [1:0][NRD-1:0]       busy;
    logic [1:0][5:0]           cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic bit legal(input int i, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < nreg[i]);
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
    if (!legal(i, a)) return 32'h0;
`ifdef RISCV_REGFILE_BYPASS_EN
    if (w0 && a0 == a) return d0;
    if (w1 && a1 == a) return d1;
`endif
    return m[i][a];
  endfunction

  function automatic logic exp_busy(input int i, input logic [4:0] a);
    if (!legal(i, a)) return 1'b0;
`ifdef RISCV_REGFILE_BYPASS_EN
    if (w1 && a1 == a && !(sset && sa == a)) return 1'b0;
`endif
    return mb[i][a];
  endfunction

  function automatic logic [5:0] exp_cnt(input int i);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mb[i][r]);
    return 6'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) begin
        m[i][r]  = 32'h0;
        mb[i][r] = 1'b0;
      end
  endtask

  // Clear first, then set, so a simultaneous set wins; port 0 data written last.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (w1 && legal(i, a1)) begin
        m[i][a1]  = d1;
        mb[i][a1] = 1'b0;
      end
      if (w0 && legal(i, a0)) m[i][a0] = d0;
      if (sset && legal(i, sa)) mb[i][sa] = 1'b1;
    end
  endtask

  task automatic step();
    exp_t e;
    if (!rstn) model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NRD; k++) begin
        e.data[i][k] = exp_rd(i, ra[k]);
        e.busy[i][k] = exp_busy(i, ra[k]);
      end
      e.cnt[i] = exp_cnt(i);
    end
    q.push_back(e);
    @(posedge clk);
    if (rstn) model_edge();
    else      model_reset();
    #1;
  endtask

  task automatic idle();
    w0 = 1'b0; w1 = 1'b0; sset = 1'b0;
    a0 = '0; a1 = '0; sa = '0; d0 = '0; d1 = '0;
  endtask

  task automatic set_ra(input logic [4:0] r0, r1, r2, r3);
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
  endtask

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  // Monitor: compares whatever the DUTs present mid-cycle against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("i_data%0d", k), rd_i[k*32 +: 32], e.data[0][k]);
        chk($sformatf("e_data%0d", k), rd_e[k*32 +: 32], e.data[1][k]);
        chk($sformatf("i_busy%0d", k), 32'(bz_i[k]), 32'(e.busy[0][k]));
        chk($sformatf("e_busy%0d", k), 32'(bz_e[k]), 32'(e.busy[1][k]));
      end
      chk("i_cnt", 32'(cnt_i), 32'(e.cnt[0]));
      chk("e_cnt", 32'(cnt_e), 32'(e.cnt[1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    set_ra(5'd0, 5'd5, 5'd7, 5'd31);
    @(posedge clk); #1;
    step();                                              // in reset
    rstn = 1'b1;
    w0 = 1; a0 = 5'd5; d0 = 32'hDEADBEEF; sset = 1; sa = 5'd7;
    step();                                              // write in release cycle
    idle(); step();
    rstn = 1'b0; step(); step();                         // asynchronous mid-run reset
    rstn = 1'b1; step();

    // x0 and out-of-range (x20 on RV32E)
    w0 = 1; a0 = 5'd0; d0 = 32'h1234; w1 = 1; a1 = 5'd20; d1 = 32'h55;
    sset = 1; sa = 5'd20; set_ra(5'd0, 5'd20, 5'd0, 5'd20);
    step(); idle(); step(); step();

    // Write collision on x3 with x3 busy
    set_ra(5'd3, 5'd3, 5'd3, 5'd3);
    sset = 1; sa = 5'd3; step();
    idle(); w0 = 1; a0 = 5'd3; d0 = 32'hA; w1 = 1; a1 = 5'd3; d1 = 32'hB; step();
    idle(); step();

    // Scoreboard set/clear priority
    set_ra(5'd4, 5'd9, 5'd12, 5'd0);
    sset = 1; sa = 5'd4;  step();
    sa = 5'd9;  step();
    sa = 5'd12; step();
    idle(); step();
    w1 = 1; a1 = 5'd9; d1 = 32'h99; sset = 1; sa = 5'd9; step();
    idle(); step();
    w1 = 1; a1 = 5'd9; d1 = 32'h77; step();
    idle(); step();

    // Same-cycle read of a port 1 write
    w0 = 1; a0 = 5'd6; d0 = 32'h0BAD0006; sset = 1; sa = 5'd6; step();
    idle(); step();
    set_ra(5'd0, 5'd6, 5'd6, 5'd0);
    w1 = 1; a1 = 5'd6; d1 = 32'hCAFE0001; step();
    idle(); step();

    // Multi-port reads
    w0 = 1; a0 = 5'd1; d0 = 32'd1; w1 = 1; a1 = 5'd2; d1 = 32'd2; step();
    idle(); w0 = 1; a0 = 5'd31; d0 = 32'd31; step();
    idle(); set_ra(5'd1, 5'd2, 5'd0, 5'd31); step();

    // Randomized traffic, biased toward low addresses for collisions
    for (int n = 0; n < 500; n++) begin
      w0   = 1'($urandom_range(0, 1));
      w1   = 1'($urandom_range(0, 1));
      sset = ($urandom_range(0, 2) == 0);
      a0   = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      a1   = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      sa   = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      d0   = $urandom;
      d1   = $urandom;
      for (int k = 0; k < NRD; k++)
        ra[k] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rstn = ($urandom_range(0, 99) != 0);
      step();
    end
    rstn = 1'b1; idle(); step();

    for (int n = 0; n < 5 && q.size() != 0; n++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised next-generation RV32I/RV32E integer register file for the decode/writeback boundary of the core. Provides N combinational read ports, two prioritised write ports (ALU and long-latency/load writeback), a per-register busy scoreboard for hazard detection, and asynchronous clearing of all state. X0 stays hardwired to zero in every configuration.

## Interface
- XLEN, 32, data width (same value as the `XLEN` config macro)
- NREG, 32, architectural register count; legal values 16 (RV32E) and 32 (RV32I)
- NRD, 2, number of read ports, 1..4
- i_clk  input  1  rising-edge clock
- i_rstn  input  1  reset, asynchronous, active-low
- i_regfile_rs_addr  input  NRD*5  read addresses, port k in bits [5k+4:5k]
- o_regfile_rs_data  output  NRD*XLEN  read data, port k in bits [XLEN*k+XLEN-1:XLEN*k]
- o_regfile_rs_busy  output  NRD  scoreboard busy flag per read port
- i_regfile_rd0_wen / i_regfile_rd0_addr / i_regfile_rd0_data  input  1 / 5 / XLEN  write port 0 (ALU)
- i_regfile_rd1_wen / i_regfile_rd1_addr / i_regfile_rd1_data  input  1 / 5 / XLEN  write port 1 (load/long-latency)
- i_regfile_sb_set  input  1  mark i_regfile_sb_addr busy (long-latency issue)
- i_regfile_sb_addr  input  5  scoreboard set address
- o_regfile_sb_cnt  output  6  number of registers currently busy

## Operation
- Storage: NREG x XLEN registers; entry 0 constant zero, never written.
- Address range: addresses >= NREG read 0, report not busy, and are ignored by writes and sets.
- Writes: a port writes on a rising edge when wen=1 and addr in [1, NREG-1].
- Both ports writing one address in the same cycle: port 0 data is stored.
- Scoreboard: one busy bit per register, bit 0 constant 0.
  - Set: i_regfile_sb_set=1 with a legal non-zero address sets the bit on the next edge.
  - Clear: a port 1 write clears the bit of its address on the next edge. Port 0 writes never change busy bits.
  - Set and clear of the same address in one cycle: the set wins, and the bit stays 1.
  - Set of an address that is already busy: no change and no error.
- o_regfile_sb_cnt: registered popcount of the busy bits, updated on the same edge as the bits. Range 0..NREG-1.

## Timing
- Reset (i_rstn=0, asynchronous): all registers 0, all busy bits 0, o_regfile_sb_cnt=0. Holds while i_rstn is low. Writes and sets in the reset-release cycle are honoured from the first rising edge with i_rstn=1.
- Reads are combinational from stored state (0-cycle latency). Written data is visible on the reads in the cycle after the edge unless bypass is enabled.
- o_regfile_rs_busy is combinational from the busy bits and the read address.

## Configuration
- RISCV_REGFILE_BYPASS_EN defined:
  - A read whose address matches an active same-cycle write returns the write data, with port 0 taking precedence.
  - A read matching an active port 1 write reports busy=0 in that cycle, unless i_regfile_sb_set targets the same address in that cycle.
- Macro undefined: reads and busy reflect stored state only, and a same-cycle write is visible one cycle later.
- Storage and scoreboard behaviour are identical in both builds.

## Structure
- Shared package/include riscv_configs.v holds `XLEN`, the register address width (5), and the NREG legal-value constants.
- Sub-module riscv_regfile_scoreboard holds the busy bits, the set/clear priority, and the popcount counter.
- The top module holds storage, write priority, the read muxes, and the bypass logic.

## Test plan
- Reset: hold i_rstn=0 for mid-run, having first written x5=32'hDEADBEEF and set busy on x7. Required: reads of x5 return 0, busy=0, cnt=0, all asynchronous to i_clk.
- X0 and range: write x0=32'h1234; with NREG=16 write x20=32'h55 and set x20. Required: x0 and x20 read 0, x20 not busy, cnt unchanged.
- Write collision: port 0 writes x3=32'hA, and port 1 writes x3=32'hB in the same cycle. Required: next-cycle read of x3 = 32'hA, and the x3 busy bit is cleared.
- Scoreboard: set x4, x9 and x12 on consecutive cycles, giving cnt=3. Then issue a port 1 write of x9 together with a set of x9. Required: x9 busy stays 1 and cnt stays 3; a later port 1 write of x9 gives cnt=2.
- Bypass (macro defined): port 1 writes x6=32'hCAFE0001 while read port 1 addresses x6. Required: same-cycle data 32'hCAFE0001 with busy=0. With the macro undefined, the same stimulus returns the old value and the old busy flag.
- Multi-port: NRD=4, all ports read x1, x2, x0 and x31 after writes of 1, 2, — and 31. Required: simultaneous reads of 1, 2, 0 and 31.
